// File: rtl/cd_spi_slave_if.sv
// cd_spi_slave_if: CSR strobe bus between the SPI slave front end and the
// byte-wide CSR block.
`timescale 1ns/100ps
interface cd_spi_slave_if;
    logic       chip_select;
    logic [4:0] csr_address;
    logic       csr_read;
    logic       csr_write;
    logic [7:0] csr_writedata;
    logic [7:0] csr_readdata;

    modport master (
        output chip_select,
        output csr_address,
        output csr_read,
        output csr_write,
        output csr_writedata,
        input  csr_readdata
    );

    modport slave (
        input  chip_select,
        input  csr_address,
        input  csr_read,
        input  csr_write,
        input  csr_writedata,
        output csr_readdata
    );
endinterface

// File: rtl/cd_spi_slave.sv
// cd_spi_slave: mode-0 SPI slave that turns host transactions into single-cycle
// CSR read/write strobes. SPI pins are synchronized into the clk domain.
`timescale 1ns/100ps
module cd_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sck,
    input  logic nss,
    input  logic sdi,
    output logic sdo,
    output logic sdo_en,
    cd_spi_slave_if.master csr
);

    typedef enum logic [1:0] {IDLE, CMD, WR_DATA, RD_DATA} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] nss_sync_q, nss_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   armed_q, armed_d;
    logic                   chip_select_q, chip_select_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_shift_q, rx_shift_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic [4:0]             csr_address_q, csr_address_d;
    logic                   csr_read_q, csr_read_d;
    logic                   csr_write_q, csr_write_d;
    logic [7:0]             csr_writedata_q, csr_writedata_d;

    logic                   sck_s, nss_s, sdi_s;
    logic                   rise, fall, active;
    logic [7:0]             rx_byte;

    // Next-state logic: synchronizers, select tracking, byte assembly, CSR strobes and MISO shifting.
    always_comb begin
        sck_s = sck_sync_q[SYNC_STAGES-1];
        nss_s = nss_sync_q[SYNC_STAGES-1];
        sdi_s = sdi_sync_q[SYNC_STAGES-1];

        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
        nss_sync_d = {nss_sync_q[SYNC_STAGES-2:0], nss};
        sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};

        rise       = sck_s & ~sck_prev_q;
        fall       = ~sck_s & sck_prev_q;
        sck_prev_d = sck_s;

        // After reset, a select only counts once nss has been seen idle high,
        // so a transaction cut off by reset cannot resume mid-byte.
        armed_d       = armed_q | nss_s;
        chip_select_d = armed_q & ~nss_s;
        // The cycle in which chip_select drops is already treated as deselected.
        active        = chip_select_q & chip_select_d;

        rx_byte         = {rx_shift_q[6:0], sdi_s};
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        rx_shift_d      = rx_shift_q;
        tx_shift_d      = tx_shift_q;
        csr_address_d   = csr_address_q;
        csr_writedata_d = csr_writedata_q;
        csr_read_d      = 1'b0;
        csr_write_d     = 1'b0;

        if (!active) begin
            state_d    = IDLE;
            bit_cnt_d  = 3'd0;
            rx_shift_d = 8'd0;
            tx_shift_d = 8'd0;
        end else begin
            if (state_q == IDLE) begin
                state_d = CMD;
            end

            // A prefetch cycle loads the read data; otherwise shift on falls inside a byte.
            if (csr_read_q) begin
                tx_shift_d = csr.csr_readdata;
            end else if (fall && (bit_cnt_q != 3'd0)) begin
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end

            if (rise) begin
                rx_shift_d = rx_byte;
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    case (state_q)
                        IDLE, CMD: begin
                            csr_address_d = rx_byte[4:0];
                            if (rx_byte[7]) begin
                                state_d = WR_DATA;
                            end else begin
                                state_d    = RD_DATA;
                                csr_read_d = 1'b1;
                            end
                        end
                        WR_DATA: begin
                            csr_writedata_d = rx_byte;
                            csr_write_d     = 1'b1;
                        end
                        RD_DATA: begin
                            csr_read_d = 1'b1;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        end
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q      <= '0;
            nss_sync_q      <= '0;
            sdi_sync_q      <= '0;
            sck_prev_q      <= 1'b0;
            armed_q         <= 1'b0;
            chip_select_q   <= 1'b0;
            state_q         <= IDLE;
            bit_cnt_q       <= 3'd0;
            rx_shift_q      <= 8'd0;
            tx_shift_q      <= 8'd0;
            csr_address_q   <= 5'd0;
            csr_read_q      <= 1'b0;
            csr_write_q     <= 1'b0;
            csr_writedata_q <= 8'd0;
        end else begin
            sck_sync_q      <= sck_sync_d;
            nss_sync_q      <= nss_sync_d;
            sdi_sync_q      <= sdi_sync_d;
            sck_prev_q      <= sck_prev_d;
            armed_q         <= armed_d;
            chip_select_q   <= chip_select_d;
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            rx_shift_q      <= rx_shift_d;
            tx_shift_q      <= tx_shift_d;
            csr_address_q   <= csr_address_d;
            csr_read_q      <= csr_read_d;
            csr_write_q     <= csr_write_d;
            csr_writedata_q <= csr_writedata_d;
        end
    end

    assign sdo               = tx_shift_q[7];
    assign sdo_en            = chip_select_q;
    assign csr.chip_select   = chip_select_q;
    assign csr.csr_address   = csr_address_q;
    assign csr.csr_read      = csr_read_q;
    assign csr.csr_write     = csr_write_q;
    assign csr.csr_writedata = csr_writedata_q;

endmodule

// File: tb/tb_cd_spi_slave.sv
// tb_cd_spi_slave: SPI host driver plus scoreboard for cd_spi_slave.
`timescale 1ns/100ps
module tb_cd_spi_slave;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 5;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic sck     = 1'b0;
    logic nss     = 1'b1;
    logic sdi     = 1'b0;
    logic sdo;
    logic sdo_en;

    cd_spi_slave_if csr();

    cd_spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sck     (sck),
        .nss     (nss),
        .sdi     (sdi),
        .sdo     (sdo),
        .sdo_en  (sdo_en),
        .csr     (csr)
    );

    // 40 MHz system clock
    always #12.5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [12:0] exp_wr_q [$];
    logic [4:0]  exp_rd_q [$];
    logic [12:0] wr_exp;
    logic [4:0]  rd_exp;

    logic [7:0] mem [32];
    logic [7:0] model_mem [32];
    logic       mem_ready = 1'b0;
    logic       step_mode = 1'b0;
    logic [7:0] step_cnt  = 8'd0;

    logic [7:0] tx_buf   [8];
    logic [7:0] rx_buf   [8];
    logic [7:0] exp_miso [8];

    function automatic logic [7:0] init_val(input int i);
        return 8'h0F + 8'(i * 29);
    endfunction

    // CSR block model: data-port stepping for address 0x15, otherwise a register file
    assign csr.csr_readdata = (step_mode && csr.csr_address == 5'h15) ? 8'hA0 + step_cnt
                                                                      : mem[csr.csr_address];

    // Register file and read-step counter updated by the strobes of the DUT
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (csr.csr_write) begin
            mem[csr.csr_address] <= csr.csr_writedata;
        end
        if (!step_mode) step_cnt <= 8'd0;
        else if (csr.csr_read) step_cnt <= step_cnt + 8'd1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every strobe the DUT presents is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (reset_n) begin
            if (csr.csr_read && csr.csr_write) checkOutput("strobe_overlap", 32'd1, 32'd0);
            if (csr.csr_write) begin
                if (exp_wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             csr.csr_address, csr.csr_writedata);
                end else begin
                    wr_exp = exp_wr_q.pop_front();
                    checkOutput("write_strobe", {19'd0, csr.csr_address, csr.csr_writedata}, {19'd0, wr_exp});
                end
            end
            if (csr.csr_read) begin
                if (exp_rd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_read: got addr 0x%0h, expected no read", csr.csr_address);
                end else begin
                    rd_exp = exp_rd_q.pop_front();
                    checkOutput("read_strobe", {27'd0, csr.csr_address}, {27'd0, rd_exp});
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic spi_bit(input logic b, output logic got);
        sdi = b;
        wait_clks(HALF);
        sck = 1'b1;
        got = sdo;
        wait_clks(HALF);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic g;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], g);
            rx[i] = g;
        end
    endtask

    // Reference model: what a transaction of n bytes should do at the CSR port and on MISO
    task automatic model_txn(input int n);
        logic [4:0] addr;
        addr        = tx_buf[0][4:0];
        exp_miso[0] = 8'd0;
        if (tx_buf[0][7]) begin
            for (int i = 1; i < n; i++) begin
                exp_wr_q.push_back({addr, tx_buf[i]});
                model_mem[addr] = tx_buf[i];
                exp_miso[i]     = 8'd0;
            end
        end else begin
            for (int i = 0; i < n; i++) exp_rd_q.push_back(addr);
            for (int i = 1; i < n; i++)
                exp_miso[i] = (step_mode && addr == 5'h15) ? 8'(8'hA0 + i - 1) : model_mem[addr];
        end
    endtask

    task automatic applyStimulus(input int n);
        model_txn(n);
        nss = 1'b0;
        wait_clks(HALF + 1);
        for (int i = 0; i < n; i++) spi_byte(tx_buf[i], rx_buf[i]);
        wait_clks(HALF + 1);
        nss = 1'b1;
        wait_clks(2 * HALF + 2);
        for (int i = 0; i < n; i++) checkOutput($sformatf("miso_byte%0d", i), {24'd0, rx_buf[i]}, {24'd0, exp_miso[i]});
    endtask

    task automatic cs_latency(input logic target, output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (csr.chip_select == target) break;
        end
        #2;
    endtask

    function automatic logic [31:0] all_outputs();
        return {14'd0, sdo, sdo_en, csr.chip_select, csr.csr_address, csr.csr_read, csr.csr_write, csr.csr_writedata};
    endfunction

    // Watchdog so the run always ends
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int lat;
        logic g;
        logic [7:0] dummy;
        for (int i = 0; i < 32; i++) model_mem[i] = init_val(i);

        wait_clks(3);
        checkOutput("reset_outputs", all_outputs(), 32'd0);
        reset_n = 1'b1;
        wait_clks(4);

        // Single write
        tx_buf[0] = 8'h84; tx_buf[1] = 8'h0A;
        applyStimulus(2);

        // Single read of address 0 (holds 0x0F)
        tx_buf[0] = 8'h00; tx_buf[1] = 8'hFF;
        applyStimulus(2);

        // Burst write to one address
        tx_buf[0] = 8'h95; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
        applyStimulus(4);

        // Abort mid data byte, with select latency measured on both edges
        nss = 1'b0;
        cs_latency(1'b1, lat);
        checkOutput("cs_rise_latency", lat, SYNC_STAGES + 1);
        checkOutput("sdo_en_follows_cs", {31'd0, sdo_en}, 32'd1);
        wait_clks(HALF);
        spi_byte(8'h84, dummy);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, g);
        wait_clks(HALF + 1);
        nss = 1'b1;
        cs_latency(1'b0, lat);
        checkOutput("cs_fall_latency", lat, SYNC_STAGES + 1);
        wait_clks(2 * HALF);
        tx_buf[0] = 8'h84; tx_buf[1] = 8'h3C;
        applyStimulus(2);

        // Reset during bit 3 of a data byte, then finish that byte
        nss = 1'b0;
        wait_clks(HALF + 1);
        spi_byte(8'h84, dummy);
        spi_bit(1'b0, g); spi_bit(1'b1, g); spi_bit(1'b0, g);
        reset_n = 1'b0;
        wait_clks(2);
        checkOutput("reset_mid_outputs", all_outputs(), 32'd0);
        reset_n = 1'b1;
        wait_clks(2);
        for (int i = 0; i < 5; i++) spi_bit(i[0] ? 1'b0 : 1'b1, g);
        wait_clks(HALF + 1);
        checkOutput("cs_ignored_after_reset", {31'd0, csr.chip_select}, 32'd0);
        nss = 1'b1;
        wait_clks(2 * HALF + 2);
        tx_buf[0] = 8'h84; tx_buf[1] = 8'h55;
        applyStimulus(2);

        // Four-byte read from the stepping data port at the minimum sck half period
        step_mode = 1'b1;
        wait_clks(2);
        tx_buf[0] = 8'h15;
        for (int i = 1; i < 5; i++) tx_buf[i] = 8'h00;
        applyStimulus(5);
        step_mode = 1'b0;
        wait_clks(2);

        // Randomized transactions
        for (int t = 0; t < 16; t++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
            applyStimulus(n);
        end

        wait_clks(5);
        checkOutput("pending_writes", exp_wr_q.size(), 32'd0);
        checkOutput("pending_reads", exp_rd_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
